// File: rtl/idvr_sext_arb.sv
// Round-robin arbiter feeding one shared sign/zero-extension datapath.
// The result sits in a one-entry output register tagged with the requester index.
module idvr_sext_arb #(
  parameter int IDW = 2,
  parameter int IW  = 8,
  parameter int OW  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [(2**IDW)-1:0]    REQ_V,
  input  logic [(2**IDW)*IW-1:0] REQ_D,
  input  logic [(2**IDW)-1:0]    REQ_M,
  output logic [(2**IDW)-1:0]    GNT,
  output logic                   O_V,
  output logic [OW-1:0]          O_D,
  output logic [IDW-1:0]         O_ID,
  input  logic                   O_RDY
);

  localparam int N = 2**IDW;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           free;
  logic           acc;
  logic [IW-1:0]  win_d;
  logic           win_m;
  logic [OW-1:0]  ext_d;

  // Scan from the pointer upward; IDW-bit addition wraps naturally.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDW'(k);
      if (!found && REQ_V[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign free  = !O_V || O_RDY;
  assign acc   = free && found && !RST;
  assign GNT   = acc ? (ONE_HOT0 << win) : '0;
  assign win_d = REQ_D[int'(win)*IW +: IW];
  assign win_m = REQ_M[win];

  generate
    if (OW > IW) begin : g_ext
      assign ext_d = {{(OW-IW){win_m & win_d[IW-1]}}, win_d};
    end else begin : g_pass
      assign ext_d = win_d;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      O_V  <= 1'b0;
      O_D  <= '0;
      O_ID <= '0;
      ptr  <= '0;
    end else if (acc) begin
      O_V  <= 1'b1;
      O_D  <= ext_d;
      O_ID <= win;
      ptr  <= win + IDW'(1);
    end else if (O_RDY) begin
      O_V  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idvr_sext_arb.sv
// Directed and random stimulus for idvr_sext_arb, checked against a
// cycle-level behavioural model plus hand-computed literal expectations.
module tb_idvr_sext_arb;

  localparam int IDW = 2;
  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int N   = 2**IDW;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_V;
  logic [N*IW-1:0] REQ_D;
  logic [N-1:0]    REQ_M;
  logic [N-1:0]    GNT;
  logic            O_V;
  logic [OW-1:0]   O_D;
  logic [IDW-1:0]  O_ID;
  logic            O_RDY;

  int total = 0;
  int bad   = 0;

  idvr_sext_arb #(.IDW(IDW), .IW(IW), .OW(OW)) dut (
    .CLK(CLK), .RST(RST), .REQ_V(REQ_V), .REQ_D(REQ_D), .REQ_M(REQ_M),
    .GNT(GNT), .O_V(O_V), .O_D(O_D), .O_ID(O_ID), .O_RDY(O_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_known = 0;
  bit            m_v;
  logic [OW-1:0] m_d;
  int            m_id;
  int            m_ptr;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [OW-1:0] extend(input logic [IW-1:0] d, input logic m);
    int val;
    val = int'(d);
    if (m && val >= (1 << (IW-1))) val = val - (1 << IW);
    return OW'(val);
  endfunction

  function automatic bit accepts(input bit rst, input logic [N-1:0] v, input bit rdy, input bit ov);
    return !rst && (v != 0) && (!ov || rdy);
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_v = 0; m_d = '0; m_id = 0; m_ptr = 0; m_known = 1;
      end else if (m_known) begin
        if (accepts(RST, REQ_V, O_RDY, m_v)) begin
          int w;
          w     = winner(REQ_V, m_ptr);
          m_v   = 1;
          m_d   = extend(REQ_D[w*IW +: IW], REQ_M[w]);
          m_id  = w;
          m_ptr = (w + 1) % N;
        end else if (O_RDY) begin
          m_v = 0;
        end
      end
    end
  end

  // Compare process: outputs checked against the model every cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_known) begin
        logic [N-1:0] eg;
        eg = '0;
        if (accepts(RST, REQ_V, O_RDY, m_v)) eg[winner(REQ_V, m_ptr)] = 1'b1;
        chk("model_gnt", 32'(GNT), 32'(eg));
        chk("model_ov", 32'(O_V), 32'(m_v));
        chk("model_od", 32'(O_D), 32'(m_d));
        chk("model_oid", 32'(O_ID), 32'(m_id));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [OW-1:0] lit_d [N];

  initial begin
    lit_d[0] = 16'hFF80;
    lit_d[1] = 16'h0080;
    lit_d[2] = 16'h007F;
    lit_d[3] = 16'hFFFF;

    RST   = 1'b1;
    REQ_V = 4'b1111;
    REQ_D = {8'hFF, 8'h7F, 8'h80, 8'h80};
    REQ_M = 4'b1101;
    O_RDY = 1'b1;
    #1;
    chk("rst_gnt", 32'(GNT), 32'h0);
    tick();
    chk("rst_gnt2", 32'(GNT), 32'h0);
    chk("rst_ov", 32'(O_V), 32'h0);
    chk("rst_od", 32'(O_D), 32'h0);
    chk("rst_oid", 32'(O_ID), 32'h0);

    // Round-robin under full load; extension results by requester.
    RST = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_gnt", 32'(GNT), 32'(1 << (k % N)));
      if (k > 0) begin
        chk("rr_ov", 32'(O_V), 32'h1);
        chk("rr_oid", 32'(O_ID), 32'((k - 1) % N));
        chk("rr_od", 32'(O_D), 32'(lit_d[(k - 1) % N]));
      end
      tick();
      #1;
    end
    chk("rr_last_oid", 32'(O_ID), 32'h3);
    chk("rr_last_od", 32'(O_D), 32'hFFFF);

    // Backpressure with requesters 1 and 2 waiting.
    O_RDY = 1'b0;
    REQ_V = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_gnt", 32'(GNT), 32'h0);
      tick();
      chk("bp_ov", 32'(O_V), 32'h1);
      chk("bp_oid", 32'(O_ID), 32'h3);
      chk("bp_od", 32'(O_D), 32'hFFFF);
    end
    O_RDY = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(GNT), 32'h2);
    tick();
    chk("bp_pop_ov", 32'(O_V), 32'h1);
    chk("bp_pop_oid", 32'(O_ID), 32'h1);
    chk("bp_pop_od", 32'(O_D), 32'h0080);
    chk("bp_next_gnt", 32'(GNT), 32'h4);
    tick();
    chk("g2_oid", 32'(O_ID), 32'h2);

    // Pointer at 3: wrap to 0, skip 1, then 3 wraps pointer to 0.
    REQ_V = 4'b0101;
    #1;
    chk("wrap_gnt0", 32'(GNT), 32'h1);
    tick();
    chk("wrap_oid0", 32'(O_ID), 32'h0);
    chk("skip_gnt2", 32'(GNT), 32'h4);
    tick();
    chk("skip_oid2", 32'(O_ID), 32'h2);
    REQ_V = 4'b1000;
    #1;
    chk("wrap_gnt3", 32'(GNT), 32'h8);
    tick();
    chk("wrap_oid3", 32'(O_ID), 32'h3);
    REQ_V = 4'b0000;
    tick();
    chk("idle_ov", 32'(O_V), 32'h0);
    chk("idle_hold_od", 32'(O_D), 32'hFFFF);
    chk("idle_hold_oid", 32'(O_ID), 32'h3);

    // Reset in the middle of a stall with pointer at 2.
    REQ_V = 4'b0010;
    tick();
    chk("mid_oid", 32'(O_ID), 32'h1);
    O_RDY = 1'b0;
    REQ_V = 4'b1111;
    tick();
    chk("mid_stall_ov", 32'(O_V), 32'h1);
    RST = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(GNT), 32'h0);
    tick();
    chk("mid_rst_ov", 32'(O_V), 32'h0);
    chk("mid_rst_od", 32'(O_D), 32'h0);
    chk("mid_rst_oid", 32'(O_ID), 32'h0);
    RST   = 1'b0;
    O_RDY = 1'b1;
    REQ_V = 4'b0110;
    #1;
    chk("mid_after_gnt", 32'(GNT), 32'h2);
    tick();

    // Random traffic, checked by the model only.
    for (int k = 0; k < 400; k++) begin
      REQ_V = N'($urandom);
      REQ_D = (N*IW)'($urandom);
      REQ_M = N'($urandom);
      O_RDY = ($urandom_range(0, 3) != 0);
      tick();
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idvr_sext_arb.md
# idvr_sext_arb

Round-robin arbiter and sequencer that shares a single sign/zero-extension datapath between N requesters. Each requester presents an IW-bit operand plus a mode bit. The block grants one requester per cycle, extends the operand to OW bits, and returns the result through a one-entry output register tagged with the requester index. It sits between several narrow producers and a single wide consumer in the IDVR datapath.

## Interface
- IDW, 2, requester index width; number of requesters N = 2**IDW
- IW, 8, operand width; IW >= 1
- OW, 16, result width; OW >= IW (OW == IW is pass-through)

- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  reset, synchronous, active-high
- REQ_V  input  N  per-requester valid; bit i belongs to requester i
- REQ_D  input  N*IW  operands; requester i occupies bits [i*IW +: IW]
- REQ_M  input  N  per-requester mode; 1 = sign-extend, 0 = zero-extend
- GNT  output  N  one-hot grant, combinational; GNT[i]=1 means requester i's operand is taken this cycle
- O_V  output  1  result valid
- O_D  output  OW  extended result
- O_ID  output  IDW  index of the requester that produced O_D
- O_RDY  input  1  consumer ready; a transfer occurs when O_V && O_RDY

## Operation
- State: output register (O_V, O_D, O_ID) and round-robin pointer PTR[IDW-1:0].
- Reset (RST=1 at an edge): O_V=0, O_D=0, O_ID=0, PTR=0. A pending result is discarded. GNT is 0 while RST=1.
- Slot free: FREE = !O_V || O_RDY.
- Accept: ACC = FREE && (|REQ_V) && !RST.
- Winner W: first index j in the order PTR, PTR+1, ..., PTR+N-1 (mod N) with REQ_V[j]=1.
- GNT = onehot(W) when ACC, else 0. GNT never has more than one bit set.
- Extension of winner operand D = REQ_D[W*IW +: IW]:
  - mode 1: O_D = {(OW-IW) copies of D[IW-1], D}
  - mode 0: O_D = {(OW-IW) zeros, D}
- On an edge with ACC: O_V<=1, O_D<=ext(D), O_ID<=W, PTR<=(W+1) mod N (natural wrap).
- On an edge with !ACC && O_RDY: O_V<=0. O_D and O_ID hold their last values.
- On an edge with !ACC && !O_RDY: all state holds.
- Requester protocol:
  - Hold REQ_V[i], operand and mode stable until the cycle GNT[i]=1.
  - Deassert REQ_V[i] after that cycle, or keep it high with the next operand.
  - Dropping REQ_V[i] before a grant is legal and leaves no state behind.
- Fairness: a continuously requesting requester is granted within N accepts.

## Timing
- Latency: operand granted in cycle t appears on O_D/O_V after edge t+1 (1 cycle).
- Throughput: 1 result per cycle while O_RDY=1. Simultaneous pop and accept in the same cycle is required; there is no bubble.
- Backpressure: while O_V && !O_RDY, GNT=0 and O_V/O_D/O_ID are stable.
- GNT depends combinationally on REQ_V, PTR, O_V, O_RDY and RST. There is no path from GNT back into any input.
- PTR changes only on accept. Idle cycles and stall cycles leave PTR unchanged.
- O_V goes low only after a transfer with no simultaneous accept, or on reset.

## Test plan
- Reset check: assert RST=1 with all REQ_V=1111. Required: GNT=0000 and O_V=0. Release RST with O_RDY=1 -> GNT=0001 first (PTR=0). O_D/O_ID valid one cycle later.
- Round-robin under load (IDW=2): REQ_V=1111, O_RDY=1 for 8 cycles. Required grant order: 0,1,2,3,0,1,2,3; O_ID follows one cycle later with no gaps.
- Extension modes (IW=8, OW=16), one operand each:
  - D=8'h80, M=1 -> O_D=16'hFF80
  - D=8'h80, M=0 -> O_D=16'h0080
  - D=8'h7F, M=1 -> O_D=16'h007F
  - D=8'hFF, M=1 -> O_D=16'hFFFF
- Backpressure: get O_V=1, then hold O_RDY=0 for 3 cycles with REQ_V=0110. Required: GNT=0000 and O_D/O_ID frozen. When O_RDY=1, the pop and the grant to requester 1 happen in the same cycle; O_V stays 1.
- Pointer wrap and skip: PTR=3 (after granting 2), REQ_V=0101. Required: grant 0, then PTR=1, next grant 2. Then REQ_V=1000 -> grant 3, PTR wraps to 0.
- Reset mid-stall: O_V=1, O_RDY=0, PTR=2, then assert RST for 1 cycle. Required: O_V=0, O_ID=0, O_D=0, PTR=0; next grant goes to the lowest requesting index.
